sram_1r1w_ctrl: RTL and testbench
=================================

Name: sram_1r1w_ctrl

Overview:
- Requester-side controller for the 16x32 1R1W byte-masked SRAM macro in the instruction cache.
- Converts valid/ready write and read request streams into macro port-0 (write) and port-1 (read) pin activity.
- Captures macro read data before it goes invalid and returns it on a buffered valid/ready response stream.
- Resolves the same-address write/read collision the macro cannot handle.

Parameters:
- ADDR_WIDTH, 4, word address width (depth = 1<<ADDR_WIDTH)
- DATA_WIDTH, 32, data word width
- NUM_WMASKS, 4, byte-enable count (DATA_WIDTH/8)
- RSP_DEPTH, 3, response FIFO entries; minimum 2; 3 sustains 1 read/cycle

Ports:
- clk  in  1  single clock; also drives macro clk0 and clk1 at top level
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write request valid
- wr_ready  out  1  write request accepted
- wr_addr  in  ADDR_WIDTH  write word address
- wr_data  in  DATA_WIDTH  write data
- wr_mask  in  NUM_WMASKS  byte enables, bit i covers data[8i+7:8i]
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request accepted
- rd_addr  in  ADDR_WIDTH  read word address
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer accepts read data
- rsp_data  out  DATA_WIDTH  read data, in request order
- sram_csb0  out  1  macro write chip select, active low
- sram_wmask0  out  NUM_WMASKS  macro write mask
- sram_addr0  out  ADDR_WIDTH  macro write address
- sram_din0  out  DATA_WIDTH  macro write data
- sram_csb1  out  1  macro read chip select, active low
- sram_addr1  out  ADDR_WIDTH  macro read address
- sram_dout1  in  DATA_WIDTH  macro read data

Behaviour:
- Reset, asynchronous:
  - wr_ready=0, rd_ready=0, rsp_valid=0; sram_csb0=1, sram_csb1=1.
  - rsp_data, the FIFO, the in-flight flag and all counters are cleared.
  - A registered flag init_done sets on the first clk edge after rst_n rises. wr_ready and rd_ready stay 0 until then.
- Macro timing model:
  - The macro registers its inputs at posedge.
  - Writes commit at negedge.
  - dout1 is valid only in the window from the following negedge+DELAY to the next posedge+T_HOLD, after which it goes X.
- Write path:
  - wr_ready = init_done, so one write per cycle with no backpressure.
  - On wr_valid&&wr_ready: sram_csb0 = 0, with sram_addr0/sram_din0/sram_wmask0 driven combinationally from the request in the same cycle.
  - A write with wr_mask==0 is accepted but keeps sram_csb0=1.
  - Otherwise: sram_csb0=1; addr/din/wmask hold their last values. sram_wmask0 is forced to 0 when idle.
- Read path:
  - Credits = RSP_DEPTH - fifo_count - inflight, using registered state only.
  - rd_ready = init_done && credits>0 && !(wr_valid && wr_mask!=0 && wr_addr==rd_addr).
  - On acceptance at edge E: sram_csb1 = 0 and sram_addr1 = rd_addr during the cycle before E, combinationally. The inflight flag sets at E.
  - At edge E+1, sram_dout1 is pushed into the FIFO and inflight clears, unless another read was accepted at E+1.
  - rsp_valid rises in the cycle after E+1, so latency is 2 edges from request acceptance.
- Same-address collision:
  - When a write and a read to the same address are presented together, the write wins and the read is held (rd_ready=0) for that cycle.
  - The read is accepted next cycle and returns the newly written data.
  - Different addresses proceed concurrently.
- Response FIFO:
  - FWFT; rsp_data = head entry.
  - Pop on rsp_valid&&rsp_ready. Push and pop may occur in the same cycle.
  - The credit scheme guarantees no overflow. Push when full is an assertion failure.
  - Order is strictly preserved. Pointers wrap modulo RSP_DEPTH.
- Throughput: with RSP_DEPTH=3 and rsp_ready held 1, one read per cycle is sustained indefinitely.
- Reset mid-operation: an in-flight read is discarded, its data is never presented, and the FIFO empties. A write accepted at the same edge as reset assertion is not guaranteed.

Decomposition:
- Package sram_ctrl_pkg: ADDR_WIDTH/DATA_WIDTH/NUM_WMASKS defaults, and a byte-mask expansion function (mask to DATA_WIDTH bit-enable).
- Sub-module sram_rsp_fifo: parameterised FWFT FIFO (depth, width) with count output.
- The controller instantiates the FIFO and the macro-pin logic.
- The bench instantiates the real macro model alongside the controller.

Test Plan:
- Reset release:
  - Stimulus: hold rst_n=0 for 3 cycles, then release.
  - Required: rd_ready/wr_ready=0 until the first edge after release, then 1; rsp_valid=0; sram_csb0=sram_csb1=1 throughout reset.
- Byte-masked write then read:
  - Stimulus: write addr 3 = 0xDEADBEEF mask 0xF; write addr 3 = 0x00001100 mask 0x2; read addr 3.
  - Required: rsp_data=0xDEAD11EF, rsp_valid exactly 2 edges after read acceptance.
- Collision:
  - Stimulus: the same cycle presents write addr 5 = 0x12345678 mask 0xF and read addr 5.
  - Required: rd_ready=0 that cycle, read accepted next cycle, rsp_data=0x12345678.
  - Also: the same case with read addr 6 is accepted immediately.
- Streaming:
  - Stimulus: 16 back-to-back reads of addrs 0..15 with rsp_ready=1.
  - Required: rd_ready never drops, 16 in-order responses on consecutive cycles.
- Backpressure:
  - Stimulus: rsp_ready=0 while issuing reads.
  - Required: exactly 3 reads accepted, then rd_ready=0; releasing rsp_ready drains 3 correct, in-order words.
- Reset mid-read:
  - Stimulus: assert rst_n=0 one cycle after read acceptance.
  - Required: no rsp_valid after reset release, FIFO empty, next read returns correct data.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared defaults and helpers for the 16x32 1R1W byte-masked SRAM controller.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_WIDTH = 4;
  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_NUM_WMASKS = SRAM_DATA_WIDTH / 8;

  // Byte enables to per-bit enables: bit i of the mask covers data[8i+7:8i].
  function automatic logic [SRAM_DATA_WIDTH-1:0] expand_mask(
    input logic [SRAM_NUM_WMASKS-1:0] mask
  );
    logic [SRAM_DATA_WIDTH-1:0] bits;
    bits = '0;
    for (int i = 0; i < SRAM_NUM_WMASKS; i++) begin
      bits[8*i +: 8] = {8{mask[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/sram_1r1w_ctrl_if.sv
// Requester-side write/read/response valid-ready bundle for sram_1r1w_ctrl.
interface sram_1r1w_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) ();

  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_WMASKS-1:0] wr_mask;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask,
    input  wr_ready,
    output rd_valid, rd_addr,
    input  rd_ready,
    input  rsp_valid, rsp_data,
    output rsp_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mask,
    output wr_ready,
    input  rd_valid, rd_addr,
    output rd_ready,
    output rsp_valid, rsp_data,
    input  rsp_ready
  );

endinterface

// File: rtl/sram_rsp_fifo.sv
// First-word-fall-through response FIFO; head entry is always visible on rdata_o.
module sram_rsp_fifo #(
  parameter  int DEPTH = 3,
  parameter  int WIDTH = 32,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;
  logic             full;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign valid_o = (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && valid_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = bump(wr_ptr_q);
    if (do_pop) rd_ptr_d = bump(rd_ptr_q);
    if (push_i && !do_pop) count_d = count_q + 1'b1;
    if (!push_i && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full));

endmodule

// File: rtl/sram_1r1w_ctrl.sv
// Valid/ready front end for the 1R1W byte-masked SRAM macro: drives macro pins,
// captures read data inside its short valid window and buffers it for the consumer.
module sram_1r1w_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int NUM_WMASKS = SRAM_NUM_WMASKS,
  parameter int RSP_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_1r1w_ctrl_if.slave       bus,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic                  init_done_q;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] addr0_q;
  logic [DATA_WIDTH-1:0] din0_q;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occupancy;
  logic                  wr_fire, collide, rd_ready, rd_fire;
  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_data;

  // A zero-mask write is accepted but never reaches the macro.
  assign wr_fire = bus.wr_valid && init_done_q && (bus.wr_mask != '0);

  // The macro cannot read an address it is writing in the same cycle; the write wins.
  assign collide = bus.wr_valid && (bus.wr_mask != '0) && (bus.wr_addr == bus.rd_addr);

  assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(inflight_q);
  assign rd_ready  = init_done_q && (occupancy < (CW+1)'(RSP_DEPTH)) && !collide;
  assign rd_fire   = bus.rd_valid && rd_ready;
  assign inflight_d = rd_fire;

  assign bus.wr_ready  = init_done_q;
  assign bus.rd_ready  = rd_ready;
  assign bus.rsp_valid = fifo_valid;
  assign bus.rsp_data  = fifo_data;

  always_comb begin
    sram_csb0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = addr0_q;
    sram_din0   = din0_q;
    if (wr_fire) begin
      sram_csb0   = 1'b0;
      sram_wmask0 = bus.wr_mask;
      sram_addr0  = bus.wr_addr;
      sram_din0   = bus.wr_data;
    end
  end

  assign sram_csb1  = !rd_fire;
  assign sram_addr1 = bus.rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done_q <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      init_done_q <= 1'b1;
      inflight_q  <= inflight_d;
    end
  end

  // Idle write pins keep showing the last issued address and data.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      addr0_q <= bus.wr_addr;
      din0_q  <= bus.wr_data;
    end
  end

  // Read data is valid at the edge after the macro registered the read.
  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .wdata_i (sram_dout1),
    .pop_i   (bus.rsp_ready),
    .valid_o (fifo_valid),
    .rdata_o (fifo_data),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_sram_1r1w_ctrl.sv
// Directed bench for sram_1r1w_ctrl with a behavioural 16x32 1R1W byte-masked macro.
module tb_sram_1r1w_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_1r1w_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NM)) bus ();

  logic          sram_csb0, sram_csb1;
  logic [NM-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0, sram_dout1;

  sram_1r1w_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_WMASKS (NM),
    .RSP_DEPTH  (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .sram_csb0   (sram_csb0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_csb1   (sram_csb1),
    .sram_addr1  (sram_addr1),
    .sram_dout1  (sram_dout1)
  );

  // Macro model: inputs registered at posedge, write commits at negedge,
  // dout1 valid from negedge+2 until posedge+1.
  logic [DW-1:0] mem [16];
  logic          csb0_r = 1'b1, csb1_r = 1'b1;
  logic [NM-1:0] wmask0_r;
  logic [AW-1:0] addr0_r, addr1_r;
  logic [DW-1:0] din0_r;

  always @(posedge clk) begin
    csb0_r   <= sram_csb0;
    wmask0_r <= sram_wmask0;
    addr0_r  <= sram_addr0;
    din0_r   <= sram_din0;
    csb1_r   <= sram_csb1;
    addr1_r  <= sram_addr1;
  end

  always @(negedge clk) begin
    logic [AW-1:0] ra;
    if (!csb0_r) begin
      for (int b = 0; b < NM; b++)
        if (wmask0_r[b]) mem[addr0_r][8*b +: 8] = din0_r[8*b +: 8];
    end
    if (!csb1_r) begin
      ra = addr1_r;
      #2 sram_dout1 = mem[ra];
      @(posedge clk);
      #1 sram_dout1 = 'x;
    end
  end

  logic [DW-1:0] model [16];
  int total = 0;
  int bad = 0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                          input logic [NM-1:0] mask);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < NM; b++)
      if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] fill_word(input int i);
    return 32'hA5C3_0000 | (32'(i) << 8) | 32'(i * 7);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic go_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [NM-1:0] mask);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    bus.wr_mask  = mask;
    at_neg();
    check("wr_ready", 32'(bus.wr_ready), 1);
    check("wr_csb0", 32'(sram_csb0), (mask == '0) ? 1 : 0);
    check("wr_wmask0", 32'(sram_wmask0), 32'(mask));
    if (mask != '0) begin
      check("wr_addr0", 32'(sram_addr0), 32'(addr));
      check("wr_din0", sram_din0, data);
    end
    go_edge();
    bus.wr_valid = 1'b0;
    model[addr] = merge(model[addr], data, mask);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    bus.rd_valid = 1'b1;
    bus.rd_addr  = addr;
    at_neg();
    check("rd_ready", 32'(bus.rd_ready), 1);
    check("rd_csb1", 32'(sram_csb1), 0);
    check("rd_addr1", 32'(sram_addr1), 32'(addr));
    go_edge();
    bus.rd_valid = 1'b0;
    at_neg();
    check("rsp_early", 32'(bus.rsp_valid), 0);
    go_edge();
    at_neg();
    check("rsp_valid", 32'(bus.rsp_valid), 1);
    check("rsp_data", bus.rsp_data, exp);
    go_edge();
    at_neg();
    check("rsp_popped", 32'(bus.rsp_valid), 0);
    go_edge();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = '0;
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = '0;
    bus.wr_data   = 32'hFFFF_FFFF;
    bus.wr_mask   = 4'hF;
    bus.rd_valid  = 1'b1;
    bus.rd_addr   = 4'd1;
    bus.rsp_ready = 1'b1;

    // Reset held with requests presented: nothing may reach the macro.
    for (int c = 0; c < 3; c++) begin
      at_neg();
      check("rst_wr_ready", 32'(bus.wr_ready), 0);
      check("rst_rd_ready", 32'(bus.rd_ready), 0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_csb0", 32'(sram_csb0), 1);
      check("rst_csb1", 32'(sram_csb1), 1);
      go_edge();
    end
    rst_n = 1'b1;
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    at_neg();
    check("preinit_wr_ready", 32'(bus.wr_ready), 0);
    check("preinit_rd_ready", 32'(bus.rd_ready), 0);
    go_edge();
    at_neg();
    check("init_wr_ready", 32'(bus.wr_ready), 1);
    check("init_rd_ready", 32'(bus.rd_ready), 1);
    check("init_rsp_valid", 32'(bus.rsp_valid), 0);
    go_edge();

    for (int i = 0; i < 16; i++) do_write(AW'(i), fill_word(i), 4'hF);

    at_neg();
    check("idle_csb0", 32'(sram_csb0), 1);
    check("idle_wmask0", 32'(sram_wmask0), 0);
    check("idle_addr0_hold", 32'(sram_addr0), 15);
    check("idle_din0_hold", sram_din0, 32'hA5C3_0F69);
    go_edge();

    // Zero-mask write is accepted but leaves the word untouched.
    do_write(4'd4, 32'hFFFF_FFFF, 4'h0);
    do_read(4'd4, 32'hA5C3_041C);

    do_write(4'd3, 32'hDEAD_BEEF, 4'hF);
    do_write(4'd3, 32'h0000_1100, 4'h2);
    do_read(4'd3, 32'hDEAD_11EF);

    // Same-address collision: write wins, read follows next cycle.
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'd5;
    bus.wr_data  = 32'h1234_5678;
    bus.wr_mask  = 4'hF;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 4'd5;
    at_neg();
    check("coll_rd_ready", 32'(bus.rd_ready), 0);
    check("coll_csb1", 32'(sram_csb1), 1);
    check("coll_csb0", 32'(sram_csb0), 0);
    go_edge();
    bus.wr_valid = 1'b0;
    model[5] = 32'h1234_5678;
    do_read(4'd5, 32'h1234_5678);

    // Different addresses proceed together.
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'd5;
    bus.wr_data  = 32'h55AA_55AA;
    bus.wr_mask  = 4'hF;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 4'd6;
    at_neg();
    check("nocoll_rd_ready", 32'(bus.rd_ready), 1);
    check("nocoll_csb0", 32'(sram_csb0), 0);
    check("nocoll_csb1", 32'(sram_csb1), 0);
    go_edge();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    model[5] = 32'h55AA_55AA;
    at_neg();
    check("nocoll_rsp_early", 32'(bus.rsp_valid), 0);
    go_edge();
    at_neg();
    check("nocoll_rsp_valid", 32'(bus.rsp_valid), 1);
    check("nocoll_rsp_data", bus.rsp_data, 32'hA5C3_062A);
    go_edge();
    do_read(4'd5, 32'h55AA_55AA);

    // Streaming: 16 back-to-back reads.
    for (int k = 0; k < 18; k++) begin
      bus.rd_valid = (k < 16);
      bus.rd_addr  = AW'(k);
      at_neg();
      if (k < 16) check("stream_rd_ready", 32'(bus.rd_ready), 1);
      if (k < 2) begin
        check("stream_rsp_idle", 32'(bus.rsp_valid), 0);
      end else begin
        check("stream_rsp_valid", 32'(bus.rsp_valid), 1);
        check("stream_rsp_data", bus.rsp_data, model[k-2]);
      end
      go_edge();
    end
    bus.rd_valid = 1'b0;

    // Backpressure: only RSP_DEPTH reads fit.
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.rd_valid = 1'b1;
      bus.rd_addr  = AW'(7 + ((k < 3) ? k : 3));
      at_neg();
      check("bp_rd_ready", 32'(bus.rd_ready), (k < 3) ? 1 : 0);
      if (k >= 2) begin
        check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
        check("bp_rsp_head", bus.rsp_data, model[7]);
      end
      go_edge();
    end
    bus.rd_valid  = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      at_neg();
      check("drain_valid", 32'(bus.rsp_valid), 1);
      check("drain_data", bus.rsp_data, model[7+j]);
      go_edge();
    end
    at_neg();
    check("drain_empty", 32'(bus.rsp_valid), 0);
    check("drain_rd_ready", 32'(bus.rd_ready), 1);
    go_edge();

    // Reset one cycle after a read is accepted: its data must never appear.
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 4'd2;
    at_neg();
    check("mid_rd_ready", 32'(bus.rd_ready), 1);
    go_edge();
    bus.rd_valid = 1'b0;
    rst_n = 1'b0;
    at_neg();
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("mid_rst_rd_ready", 32'(bus.rd_ready), 0);
    check("mid_rst_csb1", 32'(sram_csb1), 1);
    go_edge();
    go_edge();
    rst_n = 1'b1;
    at_neg();
    check("mid_rel_rsp_valid", 32'(bus.rsp_valid), 0);
    go_edge();
    for (int c = 0; c < 3; c++) begin
      at_neg();
      check("mid_post_rsp_valid", 32'(bus.rsp_valid), 0);
      check("mid_post_rd_ready", 32'(bus.rd_ready), 1);
      go_edge();
    end
    do_read(4'd4, 32'hA5C3_041C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
